// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: default widths, the HALT opcode,
// the fetch FSM state encoding and the instruction word type.
package cpu_pkg;

    localparam int          DEF_ADDR_W  = 4;
    localparam int          DEF_INSTR_W = 12;
    localparam logic [3:0]  OPC_HALT    = 4'hF;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RESP = 3'd2,
        HOLD = 3'd3,
        HALT = 3'd4
    } fetch_state_t;

    typedef logic [DEF_INSTR_W-1:0] instr_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter for the fetch stage. A redirect wins over a restart, which
// wins over the post-response increment; the increment wraps at 2^ADDR_W.
module fetch_pc_reg #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ld_zero,
    input  logic              i_ld_br,
    input  logic [ADDR_W-1:0] i_br_target,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;

    // pc update: redirect, restart at 0, or step to the next word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= '0;
        end else if (i_ld_br) begin
            r_pc <= i_br_target;
        end else if (i_ld_zero) begin
            r_pc <= '0;
        end else if (i_inc) begin
            r_pc <= r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage in front of the 16x12 instruction memory: program load port,
// PC-driven reads, instruction register with valid/ready hand-off to decode,
// branch redirect and HALT-opcode stop.
// Optional macro FETCH_PERF_CNT_EN adds saturating transfer/stall counters;
// without it fetch_cnt/stall_cnt read as 0 and no counter flops exist.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_wr_en,
    output logic [INSTR_W-1:0] mem_wdata,
    input  logic [INSTR_W-1:0] mem_instr,
    input  logic               br_valid,
    input  logic [ADDR_W-1:0]  br_target,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               busy,
    output logic               halted,
    output logic [15:0]        fetch_cnt,
    output logic [15:0]        stall_cnt
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [ADDR_W-1:0]  w_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [ADDR_W-1:0]  r_ir_pc;
    logic               r_ir_valid;

    logic w_quiet;   // IDLE or HALT: the only states that accept load/start
    logic w_load;
    logic w_start;
    logic w_br;
    logic w_xfer;
    logic w_ir_halt;

    assign w_quiet   = (r_state == IDLE) || (r_state == HALT);
    assign w_load    = w_quiet & load_en;
    assign w_start   = w_quiet & start & ~load_en;
    assign w_br      = br_valid & ~w_quiet;
    assign w_xfer    = r_ir_valid & ir_ready;
    assign w_ir_halt = (r_ir[INSTR_W-1 -: 4] == OPC_HALT);

    fetch_pc_reg #(.ADDR_W(ADDR_W)) u_pc (
        .clk        (clk),
        .rst        (reset),
        .i_ld_zero  (w_start),
        .i_ld_br    (w_br),
        .i_br_target(br_target),
        .i_inc      (r_state == RESP),
        .o_pc       (w_pc)
    );

    // next-state: a redirect overrides whatever the state would otherwise do
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, HALT: if (w_start) w_state_nxt = REQ;
            REQ:        w_state_nxt = RESP;
            RESP:       w_state_nxt = HOLD;
            HOLD:       if (w_xfer) w_state_nxt = w_ir_halt ? HALT : REQ;
            default:    w_state_nxt = IDLE;
        endcase
        if (w_br) w_state_nxt = REQ;
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // IR capture in RESP, drop on redirect (discarding the read), clear valid on hand-off
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir       <= '0;
            r_ir_pc    <= '0;
            r_ir_valid <= 1'b0;
        end else if (w_br) begin
            r_ir_valid <= 1'b0;
        end else if (r_state == RESP) begin
            r_ir       <= mem_instr;
            r_ir_pc    <= w_pc;
            r_ir_valid <= 1'b1;
        end else if (w_xfer) begin
            r_ir_valid <= 1'b0;
        end
    end

    // memory side: a load steals the address/write port only while quiet
    assign mem_addr  = w_load ? load_addr : w_pc;
    assign mem_wr_en = w_load;
    assign mem_wdata = w_load ? load_data : '0;

    assign ir       = r_ir;
    assign ir_pc    = r_ir_pc;
    assign ir_valid = r_ir_valid;
    assign busy     = ~w_quiet;
    assign halted   = (r_state == HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_stall_cnt;

    // saturating counters of hand-offs and back-pressured cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_xfer && (r_fetch_cnt != 16'hFFFF))
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            if (r_ir_valid && !ir_ready && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign stall_cnt = r_stall_cnt;
`else
    assign fetch_cnt = 16'd0;
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a registered-read memory model.
module tb_instr_fetch_unit;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        load_en = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [11:0] load_data = '0;
    logic [3:0]  mem_addr;
    logic        mem_wr_en;
    logic [11:0] mem_wdata;
    logic [11:0] mem_instr = '0;
    logic        br_valid = 1'b0;
    logic [3:0]  br_target = '0;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic [11:0] ir;
    logic [3:0]  ir_pc;
    logic        busy;
    logic        halted;
    logic [15:0] fetch_cnt;
    logic [15:0] stall_cnt;

    logic [11:0] mem [16];

    int n_chk = 0;
    int n_fail = 0;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .start(start), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .mem_addr(mem_addr),
        .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .mem_instr(mem_instr),
        .br_valid(br_valid), .br_target(br_target), .ir_valid(ir_valid),
        .ir_ready(ir_ready), .ir(ir), .ir_pc(ir_pc), .busy(busy),
        .halted(halted), .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // 16x12 memory, synchronous write, registered read
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        mem_instr <= mem[mem_addr];
    end

    typedef struct {
        logic        ld;
        logic [3:0]  la;
        logic [11:0] ldat;
        logic        st;
        logic        rdy;
        logic        e_vld;
        logic [11:0] e_ir;
        logic [3:0]  e_pc;
        logic        e_busy;
        logic        e_halt;
        logic [3:0]  e_addr;
        logic        e_we;
    } vec_t;

    vec_t tv [14];

    function automatic vec_t mk(logic ld, logic [3:0] la, logic [11:0] ldat, logic st,
                                logic rdy, logic vld, logic [11:0] eir, logic [3:0] epc,
                                logic eb, logic eh, logic [3:0] ea, logic ew);
        vec_t v;
        v.ld = ld; v.la = la; v.ldat = ldat; v.st = st; v.rdy = rdy;
        v.e_vld = vld; v.e_ir = eir; v.e_pc = epc; v.e_busy = eb;
        v.e_halt = eh; v.e_addr = ea; v.e_we = ew;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; load_en = 1'b0; br_valid = 1'b0; ir_ready = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic load_word(input logic [3:0] a, input logic [11:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        step();
        load_en = 1'b0;
    endtask

    task automatic start_fetch();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // step until ir_valid rises, bounded
    task automatic wait_valid(input string nm);
        int n = 0;
        do begin
            step();
            n++;
        end while (!ir_valid && n < 20);
        chk({nm, "_valid_timeout"}, ir_valid, 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // reset state
        step(); step();
        reset = 1'b0;
        chk("rst_ir_valid", ir_valid, 0);
        chk("rst_ir", ir, 0);
        chk("rst_ir_pc", ir_pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wr_en", mem_wr_en, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_fetch_cnt", fetch_cnt, 0);
        chk("rst_stall_cnt", stall_cnt, 0);

        // test 1: load three words, fetch through HALT; sampled after each edge
        tv[0]  = mk(1, 4'd0, 12'h123, 0, 0,  0, 12'h000, 4'd0, 0, 0, 4'd0, 1);
        tv[1]  = mk(1, 4'd1, 12'h456, 0, 0,  0, 12'h000, 4'd0, 0, 0, 4'd1, 1);
        tv[2]  = mk(1, 4'd2, 12'hF00, 0, 0,  0, 12'h000, 4'd0, 0, 0, 4'd2, 1);
        tv[3]  = mk(0, 4'd0, 12'h000, 1, 1,  0, 12'h000, 4'd0, 1, 0, 4'd0, 0);
        tv[4]  = mk(0, 4'd0, 12'h000, 0, 1,  0, 12'h000, 4'd0, 1, 0, 4'd0, 0);
        tv[5]  = mk(0, 4'd0, 12'h000, 0, 1,  1, 12'h123, 4'd0, 1, 0, 4'd1, 0);
        tv[6]  = mk(0, 4'd0, 12'h000, 0, 1,  0, 12'h123, 4'd0, 1, 0, 4'd1, 0);
        tv[7]  = mk(0, 4'd0, 12'h000, 0, 1,  0, 12'h123, 4'd0, 1, 0, 4'd1, 0);
        tv[8]  = mk(0, 4'd0, 12'h000, 0, 1,  1, 12'h456, 4'd1, 1, 0, 4'd2, 0);
        tv[9]  = mk(0, 4'd0, 12'h000, 0, 1,  0, 12'h456, 4'd1, 1, 0, 4'd2, 0);
        tv[10] = mk(0, 4'd0, 12'h000, 0, 1,  0, 12'h456, 4'd1, 1, 0, 4'd2, 0);
        tv[11] = mk(0, 4'd0, 12'h000, 0, 1,  1, 12'hF00, 4'd2, 1, 0, 4'd3, 0);
        tv[12] = mk(0, 4'd0, 12'h000, 0, 1,  0, 12'hF00, 4'd2, 0, 1, 4'd3, 0);
        tv[13] = mk(0, 4'd0, 12'h000, 0, 1,  0, 12'hF00, 4'd2, 0, 1, 4'd3, 0);
        for (int i = 0; i < 14; i++) begin
            load_en = tv[i].ld; load_addr = tv[i].la; load_data = tv[i].ldat;
            start = tv[i].st; ir_ready = tv[i].rdy;
            step();
            chk($sformatf("t1_v%0d_ir_valid", i), ir_valid, tv[i].e_vld);
            chk($sformatf("t1_v%0d_ir", i), ir, tv[i].e_ir);
            chk($sformatf("t1_v%0d_ir_pc", i), ir_pc, tv[i].e_pc);
            chk($sformatf("t1_v%0d_busy", i), busy, tv[i].e_busy);
            chk($sformatf("t1_v%0d_halted", i), halted, tv[i].e_halt);
            chk($sformatf("t1_v%0d_mem_addr", i), mem_addr, tv[i].e_addr);
            chk($sformatf("t1_v%0d_mem_wr_en", i), mem_wr_en, tv[i].e_we);
        end
        load_en = 1'b0; start = 1'b0;
        chk("t1_fetch_cnt", fetch_cnt, PERF ? 3 : 0);

        // test 2: back-pressure on 456 for 5 cycles
        do_reset();
        ir_ready = 1'b1;
        start_fetch();
        wait_valid("t2_a");
        chk("t2_first_ir", ir, 12'h123);
        step();                       // hand off 123
        ir_ready = 1'b0;
        wait_valid("t2_b");
        chk("t2_stall_ir", ir, 12'h456);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("t2_hold%0d_ir", i), ir, 12'h456);
            chk($sformatf("t2_hold%0d_valid", i), ir_valid, 1);
        end
        chk("t2_stall_cnt", stall_cnt, PERF ? 5 : 0);
        ir_ready = 1'b1;
        step();
        chk("t2_released_valid", ir_valid, 0);
        chk("t2_stall_cnt_after", stall_cnt, PERF ? 5 : 0);
        chk("t2_fetch_cnt", fetch_cnt, PERF ? 2 : 0);

        // test 3: redirect to A during RESP of pc3
        do_reset();
        load_word(4'd0, 12'h001);
        load_word(4'd1, 12'h002);
        load_word(4'd2, 12'h003);
        load_word(4'd3, 12'h0EE);
        load_word(4'hA, 12'h0AA);
        ir_ready = 1'b1;
        start_fetch();
        for (int k = 0; k < 3; k++) begin
            wait_valid("t3_seq");
            chk($sformatf("t3_seq%0d_pc", k), ir_pc, k);
        end
        step();                       // hand off pc2 -> REQ pc3
        step();                       // REQ -> RESP pc3
        chk("t3_resp_busy", busy, 1);
        chk("t3_resp_valid", ir_valid, 0);
        br_valid = 1'b1; br_target = 4'hA;
        step();
        br_valid = 1'b0;
        chk("t3_br_valid", ir_valid, 0);
        chk("t3_br_addr", mem_addr, 4'hA);
        wait_valid("t3_tgt");
        chk("t3_tgt_pc", ir_pc, 4'hA);
        chk("t3_tgt_ir", ir, 12'h0AA);

        // test 4: no HALT in program, 17 fetches wrap pc 15 -> 0
        do_reset();
        for (int i = 0; i < 16; i++) load_word(4'(i), {4'h0, 4'(i), ~4'(i)});
        ir_ready = 1'b1;
        start_fetch();
        for (int k = 0; k < 17; k++) begin
            wait_valid("t4_seq");
            chk($sformatf("t4_seq%0d_pc", k), ir_pc, k % 16);
            chk($sformatf("t4_seq%0d_ir", k), ir, {4'h0, 4'(k % 16), ~4'(k % 16)});
        end

        // test 5: asynchronous reset while holding an instruction
        do_reset();
        ir_ready = 1'b0;
        start_fetch();
        wait_valid("t5");
        #2;
        reset = 1'b1;
        #1;
        chk("t5_ir_valid", ir_valid, 0);
        chk("t5_ir", ir, 0);
        chk("t5_ir_pc", ir_pc, 0);
        chk("t5_pc", mem_addr, 0);
        chk("t5_busy", busy, 0);
        chk("t5_halted", halted, 0);
        step();
        reset = 1'b0;

        // test 6: load+start in HALT writes only; start alone then refetches from 0
        load_word(4'd0, 12'hF12);
        ir_ready = 1'b1;
        start_fetch();
        wait_valid("t6_a");
        chk("t6_a_ir", ir, 12'hF12);
        step();
        chk("t6_halted", halted, 1);
        load_en = 1'b1; load_addr = 4'd5; load_data = 12'h555; start = 1'b1;
        step();
        chk("t6_ld_halted", halted, 1);
        chk("t6_ld_busy", busy, 0);
        chk("t6_ld_addr", mem_addr, 4'd5);
        chk("t6_ld_we", mem_wr_en, 1);
        load_en = 1'b0;
        chk("t6_mem5", mem[5], 12'h555);
        step();
        start = 1'b0;
        chk("t6_st_busy", busy, 1);
        chk("t6_st_halted", halted, 0);
        chk("t6_st_addr", mem_addr, 0);
        wait_valid("t6_b");
        chk("t6_b_pc", ir_pc, 0);
        chk("t6_b_ir", ir, 12'hF12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
